// File: rtl/bit_reverse_printer.sv
// Collects WIDTH ASCII binary digits from the UART and prints them bit-reversed, followed by CR LF.
// Define BIT_REVERSE_PRINTER_ECHO_EN to echo each digit and prefix the printout with '='.
module bit_reverse_printer #(
  parameter int WIDTH      = 8,
  parameter int GAP_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       rx_data,
  input  logic             new_rx_data,
  input  logic             tx_busy,
  output logic [7:0]       tx_data,
  output logic             new_tx_data,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int IW = $clog2(WIDTH);

  typedef enum logic [2:0] {
    COLLECT,
    SEND_EQ,
    SEND_BITS,
    SEND_CR,
    SEND_LF
  } state_t;

  state_t           state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] shreg;
  logic [IW-1:0]    index;
  logic [3:0]       gap;
`ifdef BIT_REVERSE_PRINTER_ECHO_EN
  logic             echo_pend;
  logic [7:0]       echo_byte;
`endif

  logic             is_digit;
  logic             is_esc;
  logic             can_send;
  logic [WIDTH-1:0] captured;
  logic [WIDTH-1:0] reversed;

  assign is_digit = new_rx_data && (rx_data == 8'h30 || rx_data == 8'h31);
  assign is_esc   = new_rx_data && (rx_data == 8'h1B);
  assign captured = {shreg[WIDTH-2:0], rx_data[0]};
  // The strobe cycle itself is also blocked; tx_busy only rises one cycle after it.
  assign can_send = !tx_busy && (gap == 4'd0) && !new_tx_data;
  assign busy     = (state != COLLECT);

  always_comb begin
    reversed = '0;
    for (int i = 0; i < WIDTH; i++) reversed[i] = captured[WIDTH-1-i];
  end

  // Send states issue a byte when allowed and advance during the strobe cycle, so
  // receive strobes coinciding with the final LF strobe still see busy=1.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= COLLECT;
      count        <= '0;
      shreg        <= '0;
      index        <= '0;
      gap          <= '0;
      tx_data      <= 8'h00;
      new_tx_data  <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
`ifdef BIT_REVERSE_PRINTER_ECHO_EN
      echo_pend    <= 1'b0;
      echo_byte    <= 8'h00;
`endif
    end else begin
      new_tx_data  <= 1'b0;
      result_valid <= 1'b0;
      if (gap != 4'd0) gap <= gap - 4'd1;

      case (state)
        COLLECT: begin
`ifdef BIT_REVERSE_PRINTER_ECHO_EN
          if (echo_pend && can_send) begin
            tx_data     <= echo_byte;
            new_tx_data <= 1'b1;
            gap         <= 4'(GAP_CYCLES);
            echo_pend   <= 1'b0;
          end
`endif
          if (is_digit) begin
`ifdef BIT_REVERSE_PRINTER_ECHO_EN
            echo_byte <= rx_data;
            echo_pend <= 1'b1;
`endif
            if (count == CW'(WIDTH - 1)) begin
              result       <= reversed;
              result_valid <= 1'b1;
              count        <= '0;
              shreg        <= '0;
              index        <= IW'(WIDTH - 1);
`ifdef BIT_REVERSE_PRINTER_ECHO_EN
              state        <= SEND_EQ;
`else
              state        <= SEND_BITS;
`endif
            end else begin
              shreg <= captured;
              count <= count + CW'(1);
            end
          end else if (is_esc) begin
            shreg <= '0;
            count <= '0;
          end
        end

`ifdef BIT_REVERSE_PRINTER_ECHO_EN
        // Flush the pending echo of the final digit before the '=' separator.
        SEND_EQ: begin
          if (new_tx_data && tx_data == 8'h3D) begin
            state <= SEND_BITS;
          end else if (can_send) begin
            new_tx_data <= 1'b1;
            gap         <= 4'(GAP_CYCLES);
            if (echo_pend) begin
              tx_data   <= echo_byte;
              echo_pend <= 1'b0;
            end else begin
              tx_data   <= 8'h3D;
            end
          end
        end
`endif

        SEND_BITS: begin
          if (new_tx_data) begin
            if (index == '0) state <= SEND_CR;
            else             index <= index - IW'(1);
          end else if (can_send) begin
            tx_data     <= {7'b0011000, result[index]};
            new_tx_data <= 1'b1;
            gap         <= 4'(GAP_CYCLES);
          end
        end

        SEND_CR: begin
          if (new_tx_data) begin
            state <= SEND_LF;
          end else if (can_send) begin
            tx_data     <= 8'h0D;
            new_tx_data <= 1'b1;
            gap         <= 4'(GAP_CYCLES);
          end
        end

        SEND_LF: begin
          if (new_tx_data) begin
            state <= COLLECT;
          end else if (can_send) begin
            tx_data     <= 8'h0A;
            new_tx_data <= 1'b1;
            gap         <= 4'(GAP_CYCLES);
          end
        end

        default: state <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_bit_reverse_printer.sv
// Directed bench for bit_reverse_printer: 8- and 16-digit instances, plus a 4-digit echo instance.
// Printed bytes are logged as one char each ('r' = CR, 'n' = LF) and compared against hand-computed strings.
module tb_bit_reverse_printer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic tx_busy = 1'b0;
  logic nrx8 = 1'b0, nrx16 = 1'b0, nrx4 = 1'b0;

  logic [7:0]  tx_data8, tx_data16, tx_data4;
  logic        new_tx_data8, new_tx_data16, new_tx_data4;
  logic [7:0]  result8;
  logic [15:0] result16;
  logic [3:0]  result4;
  logic        result_valid8, result_valid16, result_valid4;
  logic        busy8, busy16, busy4;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  bit_reverse_printer #(.WIDTH(8), .GAP_CYCLES(1)) dut8 (
    .clk(clk), .rst(rst), .rx_data(rx_data), .new_rx_data(nrx8), .tx_busy(tx_busy),
    .tx_data(tx_data8), .new_tx_data(new_tx_data8), .result(result8),
    .result_valid(result_valid8), .busy(busy8));

  bit_reverse_printer #(.WIDTH(16), .GAP_CYCLES(1)) dut16 (
    .clk(clk), .rst(rst), .rx_data(rx_data), .new_rx_data(nrx16), .tx_busy(tx_busy),
    .tx_data(tx_data16), .new_tx_data(new_tx_data16), .result(result16),
    .result_valid(result_valid16), .busy(busy16));

  bit_reverse_printer #(.WIDTH(4), .GAP_CYCLES(1)) dut4 (
    .clk(clk), .rst(rst), .rx_data(rx_data), .new_rx_data(nrx4), .tx_busy(tx_busy),
    .tx_data(tx_data4), .new_tx_data(new_tx_data4), .result(result4),
    .result_valid(result_valid4), .busy(busy4));

  // Transmit monitors: byte log, adjacent strobes, strobes issued while tx_busy was high.
  string str8 = "", str16 = "", str4 = "";
  int    rv8 = 0, adj8 = 0, bv8 = 0, adj16 = 0, bv16 = 0, adj4 = 0;
  logic  prev8 = 1'b0, prev16 = 1'b0, prev4 = 1'b0, bprev = 1'b0;

  function automatic string fmt(input logic [7:0] b);
    if (b == 8'h0D) return "r";
    if (b == 8'h0A) return "n";
    return $sformatf("%c", b);
  endfunction

  always @(negedge clk) begin
    if (new_tx_data8) begin
      str8 <= {str8, fmt(tx_data8)};
      if (prev8) adj8 <= adj8 + 1;
      if (bprev) bv8 <= bv8 + 1;
    end
    if (new_tx_data16) begin
      str16 <= {str16, fmt(tx_data16)};
      if (prev16) adj16 <= adj16 + 1;
      if (bprev) bv16 <= bv16 + 1;
    end
    if (new_tx_data4) begin
      str4 <= {str4, fmt(tx_data4)};
      if (prev4) adj4 <= adj4 + 1;
    end
    if (result_valid8) rv8 <= rv8 + 1;
    prev8  <= new_tx_data8;
    prev16 <= new_tx_data16;
    prev4  <= new_tx_data4;
    bprev  <= tx_busy;
  end

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk);
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic send_byte(input int which, input logic [7:0] b);
    @(posedge clk); #1;
    rx_data = b;
    if (which == 8) nrx8 = 1'b1;
    else if (which == 16) nrx16 = 1'b1;
    else nrx4 = 1'b1;
    @(posedge clk); #1;
    nrx8 = 1'b0; nrx16 = 1'b0; nrx4 = 1'b0;
  endtask

  task automatic type_str(input int which, input string s, input int spacing);
    for (int i = 0; i < s.len(); i++) begin
      repeat (spacing) @(posedge clk);
      send_byte(which, s[i]);
    end
  endtask

  function automatic int log_len(input int which);
    if (which == 8) return str8.len();
    if (which == 16) return str16.len();
    return str4.len();
  endfunction

  // Waits for the log to reach n bytes, then lets a few more cycles pass to catch extras.
  task automatic wait_bytes(input int which, input int n, input int budget);
    bit ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(posedge clk); #1;
      if (log_len(which) >= n) begin ok = 1'b1; break; end
    end
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL wait_bytes dut%0d: got %0d bytes, required %0d", which, log_len(which), n);
    end
    repeat (10) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if ({tx_data8, new_tx_data8, result8, result_valid8, busy8} !== 19'd0) begin
      fails++;
      $display("FAIL reset_dut8: got %h/%b/%h/%b/%b, required all zero",
               tx_data8, new_tx_data8, result8, result_valid8, busy8);
    end
    tests++;
    if ({tx_data16, new_tx_data16, result16, result_valid16, busy16} !== 27'd0) begin
      fails++;
      $display("FAIL reset_dut16: got %h/%b/%h/%b/%b, required all zero",
               tx_data16, new_tx_data16, result16, result_valid16, busy16);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int s0, r0, a0, b0;
    string got;
    do_reset();
    s0 = str8.len(); r0 = rv8; a0 = adj8; b0 = bv8;
    type_str(8, "11010000", 1);
    tests++;
    if (result_valid8 !== 1'b1 || new_tx_data8 !== 1'b0 || result8 !== 8'h0B) begin
      fails++;
      $display("FAIL basic_latency: got valid=%b strobe=%b result=%h, required 1 0 0b",
               result_valid8, new_tx_data8, result8);
    end
    wait_bytes(8, s0 + 10, 100);
    got = str8.substr(s0, str8.len() - 1);
    tests++;
    if (got != "00001011rn") begin
      fails++;
      $display("FAIL basic_print: got %s, required 00001011rn", got);
    end
    tests++;
    if (rv8 - r0 !== 1) begin
      fails++;
      $display("FAIL basic_valid_count: got %0d, required 1", rv8 - r0);
    end
    tests++;
    if (adj8 !== a0 || bv8 !== b0) begin
      fails++;
      $display("FAIL basic_handshake: got adjacent=%0d busy_viol=%0d, required 0 0", adj8 - a0, bv8 - b0);
    end
    tests++;
    if (busy8 !== 1'b0) begin
      fails++;
      $display("FAIL basic_idle: got busy=%b, required 0", busy8);
    end
  endtask

  task automatic test_esc();
    int s0;
    string got;
    do_reset();
    s0 = str8.len();
    type_str(8, "101", 1);
    send_byte(8, 8'h1B);
    type_str(8, "00000001", 1);
    tests++;
    if (result8 !== 8'h80) begin
      fails++;
      $display("FAIL esc_result: got %h, required 80", result8);
    end
    wait_bytes(8, s0 + 10, 100);
    got = str8.substr(s0, str8.len() - 1);
    tests++;
    if (got != "10000000rn") begin
      fails++;
      $display("FAIL esc_print: got %s, required 10000000rn", got);
    end
  endtask

  task automatic test_ignore();
    int s0;
    string got;
    do_reset();
    s0 = str8.len();
    type_str(8, "1x0 10101 0", 1);
    tests++;
    if (result8 !== 8'h55) begin
      fails++;
      $display("FAIL ignore_result: got %h, required 55", result8);
    end
    wait_bytes(8, s0 + 10, 100);
    got = str8.substr(s0, str8.len() - 1);
    tests++;
    if (got != "01010101rn") begin
      fails++;
      $display("FAIL ignore_print: got %s, required 01010101rn", got);
    end
  endtask

  task automatic test_busy_hold();
    int s0, b0, a0;
    bit seen = 1'b0;
    string got;
    do_reset();
    s0 = str16.len(); b0 = bv16; a0 = adj16;
    type_str(16, "1100000000000000", 1);
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (new_tx_data16) begin seen = 1'b1; break; end
    end
    tests++;
    if (!seen) begin
      fails++;
      $display("FAIL hold_first_strobe: got none within 20 cycles, required one");
    end
    tx_busy = 1'b1;
    type_str(16, "111", 2);
    repeat (38) @(posedge clk);
    #1;
    tests++;
    if (str16.len() - s0 !== 1) begin
      fails++;
      $display("FAIL hold_no_strobe: got %0d bytes during hold, required 1", str16.len() - s0);
    end
    tx_busy = 1'b0;
    wait_bytes(16, s0 + 18, 200);
    got = str16.substr(s0, str16.len() - 1);
    tests++;
    if (got != "0000000000000011rn" || result16 !== 16'h0003) begin
      fails++;
      $display("FAIL hold_print: got %s result=%h, required 0000000000000011rn result=0003", got, result16);
    end
    tests++;
    if (bv16 !== b0 || adj16 !== a0) begin
      fails++;
      $display("FAIL hold_handshake: got busy_viol=%0d adjacent=%0d, required 0 0", bv16 - b0, adj16 - a0);
    end
    s0 = str16.len();
    type_str(16, "1000000000000000", 1);
    wait_bytes(16, s0 + 18, 200);
    got = str16.substr(s0, str16.len() - 1);
    tests++;
    if (got != "0000000000000001rn" || result16 !== 16'h0001) begin
      fails++;
      $display("FAIL hold_next_entry: got %s result=%h, required 0000000000000001rn result=0001", got, result16);
    end
  endtask

  task automatic test_reset_mid();
    int s0, seen;
    string got;
    do_reset();
    seen = 0;
    type_str(8, "11110000", 1);
    for (int c = 0; c < 50 && seen < 3; c++) begin
      @(posedge clk); #1;
      if (new_tx_data8) seen++;
    end
    tests++;
    if (seen !== 3) begin
      fails++;
      $display("FAIL midrst_three_bytes: got %0d strobes, required 3", seen);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    tests++;
    if (new_tx_data8 !== 1'b0 || result8 !== 8'h00 || busy8 !== 1'b0 || result_valid8 !== 1'b0) begin
      fails++;
      $display("FAIL midrst_state: got strobe=%b result=%h busy=%b valid=%b, required 0 00 0 0",
               new_tx_data8, result8, busy8, result_valid8);
    end
    rst = 1'b0;
    s0 = str8.len();
    repeat (20) @(posedge clk);
    #1;
    tests++;
    if (str8.len() !== s0) begin
      fails++;
      $display("FAIL midrst_silent: got %0d bytes after reset, required 0", str8.len() - s0);
    end
    type_str(8, "01100000", 1);
    wait_bytes(8, s0 + 10, 100);
    got = str8.substr(s0, str8.len() - 1);
    tests++;
    if (got != "00000110rn" || result8 !== 8'h06) begin
      fails++;
      $display("FAIL midrst_fresh: got %s result=%h, required 00000110rn result=06", got, result8);
    end
  endtask

  task automatic test_echo();
    int s0, a0;
    string got;
    do_reset();
    s0 = str4.len(); a0 = adj4;
    type_str(4, "0111", 4);
    wait_bytes(4, s0 + 11, 100);
    got = str4.substr(s0, str4.len() - 1);
    tests++;
    if (got != "0111=1110rn") begin
      fails++;
      $display("FAIL echo_print: got %s, required 0111=1110rn", got);
    end
    tests++;
    if (result4 !== 4'hE || adj4 !== a0) begin
      fails++;
      $display("FAIL echo_result: got result=%h adjacent=%0d, required e 0", result4, adj4 - a0);
    end
  endtask

  initial begin
    test_reset();
`ifdef BIT_REVERSE_PRINTER_ECHO_EN
    test_echo();
`else
    test_basic();
    test_esc();
    test_ignore();
    test_busy_hold();
    test_reset_mid();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
